fetch_stage: RTL

Instruction fetch front end for the processor; sits directly upstream of decode and drives the synchronous instruction memory (insn_m).
- Holds the PC and issues one read per cycle.
- Captures read data into a 2-entry buffer and presents {insn, pc} to decode over a valid/ready handshake.
- Handles branch redirects by flushing buffered and in-flight fetches.

---
 rtl/fetch_stage_if.sv | 30 +++
 rtl/fetch_stage.sv | 122 ++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// ============================================================================
// fetch_stage_if : instruction-memory read bus and fetch-to-decode handshake
// Rev 1.0
// ============================================================================
`default_nettype none

interface fetch_stage_if #(
   parameter int ADDR_W = 8,
   parameter int INSN_W = 16
);
   logic              imem_en;
   logic [ADDR_W-1:0] imem_addr;
   logic [INSN_W-1:0] imem_rdata;
   logic              out_valid;
   logic              out_ready;
   logic [INSN_W-1:0] out_insn;
   logic [ADDR_W-1:0] out_pc;

   modport master (
      output imem_en, imem_addr, out_valid, out_insn, out_pc,
      input  imem_rdata, out_ready
   );

   modport slave (
      input  imem_en, imem_addr, out_valid, out_insn, out_pc,
      output imem_rdata, out_ready
   );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : PC, one-per-cycle imem issue, 2-entry buffer to decode.
// Optional HALT detection under FETCH_HALT_DETECT_EN.            Rev 1.0
// ============================================================================
`default_nettype none

module fetch_stage #(
   parameter int                ADDR_W   = 8,
   parameter int                INSN_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              redirect_valid,
   input  wire logic [ADDR_W-1:0] redirect_pc,
   output logic                   halted,
   fetch_stage_if.master          bus
);

   logic [ADDR_W-1:0] pc;
   logic [1:0]        count;
   logic              inflight;
   logic              squash;
   logic [ADDR_W-1:0] inflight_pc;
   logic [INSN_W-1:0] buf0_insn;
   logic [ADDR_W-1:0] buf0_pc;
   logic [INSN_W-1:0] buf1_insn;
   logic [ADDR_W-1:0] buf1_pc;

   logic pop;
   logic push;
   logic issue;
   logic halt_push;

   assign bus.out_valid = ~rst & (count != 2'd0);
   assign bus.out_insn  = buf0_insn;
   assign bus.out_pc    = buf0_pc;
   assign bus.imem_en   = issue;
   assign bus.imem_addr = pc;

   // Occupancy after this edge (count + inflight - pop) must stay below 2.
   assign pop   = bus.out_valid & bus.out_ready;
   assign push  = inflight & ~squash;
   assign issue = ~rst & ~redirect_valid & ~halted &
                  (({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

`ifdef FETCH_HALT_DETECT_EN
   logic halted_q;

   assign halt_push = push & (bus.imem_rdata == '0);
   assign halted    = halted_q;

   always_ff @(posedge clk) begin
      if (rst || redirect_valid) begin
         halted_q <= 1'b0;
      end else if (halt_push) begin
         halted_q <= 1'b1;
      end
   end
`else
   assign halt_push = 1'b0;
   assign halted    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         count    <= 2'd0;
         inflight <= 1'b0;
         squash   <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_pc <= pc;
         end
         if (redirect_valid) begin
            pc     <= redirect_pc;
            count  <= 2'd0;
            squash <= inflight;
         end else begin
            if (issue) begin
               pc <= pc + 1'b1;
            end
            // A request issued alongside a HALT push must not land behind it.
            squash <= halt_push & issue;
            case ({push, pop})
               2'b11: begin
                  if (count == 2'd2) begin
                     buf0_insn <= buf1_insn;
                     buf0_pc   <= buf1_pc;
                     buf1_insn <= bus.imem_rdata;
                     buf1_pc   <= inflight_pc;
                  end else begin
                     buf0_insn <= bus.imem_rdata;
                     buf0_pc   <= inflight_pc;
                  end
               end
               2'b10: begin
                  if (count == 2'd0) begin
                     buf0_insn <= bus.imem_rdata;
                     buf0_pc   <= inflight_pc;
                  end else begin
                     buf1_insn <= bus.imem_rdata;
                     buf1_pc   <= inflight_pc;
                  end
                  count <= count + 1'b1;
               end
               2'b01: begin
                  buf0_insn <= buf1_insn;
                  buf0_pc   <= buf1_pc;
                  count     <= count - 1'b1;
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire
